// File: rtl/dma_arbiter_if.sv
// Shared DMA request/bus bundle between the two DMA masters, the arbiter and the memory backbone.
interface dma_arbiter_if;
   localparam int unsigned DW = 16;

   logic          req0,  req1;
   logic [DW-1:0] addr0, addr1;
   logic          we0,   we1;
   logic [DW-1:0] din0,  din1;
   logic          lock0, lock1;
   logic          ack0,  ack1;
   logic [DW-1:0] dout;
   logic          dma_en;
   logic [DW-1:0] dma_addr;
   logic          dma_we;
   logic [DW-1:0] dma_din;
   logic          dma_ready;
   logic [DW-1:0] dma_dout;

   // Arbiter side: serves the masters, drives the backbone
   modport slave (
      input  req0, req1, addr0, addr1, we0, we1, din0, din1, lock0, lock1,
      output ack0, ack1, dout,
      output dma_en, dma_addr, dma_we, dma_din,
      input  dma_ready, dma_dout
   );

   // Environment side: the requesting masters plus the memory backbone
   modport master (
      output req0, req1, addr0, addr1, we0, we1, din0, din1, lock0, lock1,
      input  ack0, ack1, dout,
      input  dma_en, dma_addr, dma_we, dma_din,
      output dma_ready, dma_dout
   );
endinterface

// File: rtl/dma_arbiter.sv
// Two-master round-robin DMA arbiter with key-region screening and HALT until the reset-handler fetch.
// Optional burst lock is compiled in with DMA_ARB_BURST_EN.
module dma_arbiter #(
   parameter logic [15:0] KMEM_BASE     = 16'hFEFE,
   parameter logic [15:0] KMEM_SIZE     = 16'h001F,
   parameter logic [15:0] RESET_HANDLER = 16'h0000,
   parameter int unsigned MAX_BURST     = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [15:0]   pc,
   dma_arbiter_if.slave  bus,
   output logic          key_violation
);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, HALT} state_t;

   state_t      state;
   logic        rr;          // 1: master 1 wins a tie
   logic        dma_en_q;
   logic [15:0] dma_addr_q;
   logic        dma_we_q;
   logic [15:0] dma_din_q;

   // Region end evaluated at 17 bits so it can never wrap below the base
   function automatic logic in_key(input logic [15:0] a);
      return ({1'b0, a} >= {1'b0, KMEM_BASE}) &&
             ({1'b0, a} <  ({1'b0, KMEM_BASE} + {1'b0, KMEM_SIZE}));
   endfunction

   // Arbitration candidate in IDLE
   logic        cand_valid_c, cand1_c;
   logic [15:0] cand_addr_c, cand_din_c;
   logic        cand_we_c;
   assign cand_valid_c = bus.req0 | bus.req1;
   assign cand1_c      = bus.req1 & (~bus.req0 | rr);
   assign cand_addr_c  = cand1_c ? bus.addr1 : bus.addr0;
   assign cand_we_c    = cand1_c ? bus.we1   : bus.we0;
   assign cand_din_c   = cand1_c ? bus.din1  : bus.din0;

   // Current owner's request fields while granted
   logic        gnt1_c;
   logic [15:0] cur_addr_c, cur_din_c;
   logic        cur_we_c;
   logic        more_c;
   assign gnt1_c     = (state == GRANT1);
   assign cur_addr_c = gnt1_c ? bus.addr1 : bus.addr0;
   assign cur_we_c   = gnt1_c ? bus.we1   : bus.we0;
   assign cur_din_c  = gnt1_c ? bus.din1  : bus.din0;

`ifdef DMA_ARB_BURST_EN
   localparam int unsigned CW = 5;
   logic [CW-1:0] burst_cnt;
   logic          cur_req_c, cur_lock_c;
   assign cur_req_c  = gnt1_c ? bus.req1  : bus.req0;
   assign cur_lock_c = gnt1_c ? bus.lock1 : bus.lock0;
   assign more_c     = cur_lock_c & cur_req_c & (burst_cnt < CW'(MAX_BURST - 1));
`else
   logic unused_lock_c;
   assign unused_lock_c = bus.lock0 ^ bus.lock1;
   assign more_c        = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= HALT;
         key_violation <= 1'b1;
         rr            <= 1'b0;
         dma_en_q      <= 1'b0;
         dma_addr_q    <= 16'h0000;
         dma_we_q      <= 1'b0;
         dma_din_q     <= 16'h0000;
`ifdef DMA_ARB_BURST_EN
         burst_cnt     <= '0;
`endif
      end else begin
         case (state)
            HALT: begin
               if (pc == RESET_HANDLER) begin
                  state         <= IDLE;
                  key_violation <= 1'b0;
               end
            end
            IDLE: begin
               if (cand_valid_c) begin
                  if (in_key(cand_addr_c)) begin
                     state         <= HALT;
                     key_violation <= 1'b1;
                  end else begin
                     state      <= cand1_c ? GRANT1 : GRANT0;
                     dma_en_q   <= 1'b1;
                     dma_addr_q <= cand_addr_c;
                     dma_we_q   <= cand_we_c;
                     dma_din_q  <= cand_din_c;
                  end
               end
            end
            GRANT0, GRANT1: begin
               if (bus.dma_ready) begin
                  if (more_c && in_key(cur_addr_c)) begin
                     state         <= HALT;
                     key_violation <= 1'b1;
                     dma_en_q      <= 1'b0;
`ifdef DMA_ARB_BURST_EN
                     burst_cnt     <= '0;
`endif
                  end else if (more_c) begin
                     dma_addr_q <= cur_addr_c;
                     dma_we_q   <= cur_we_c;
                     dma_din_q  <= cur_din_c;
`ifdef DMA_ARB_BURST_EN
                     burst_cnt  <= burst_cnt + CW'(1);
`endif
                  end else begin
                     state    <= IDLE;
                     dma_en_q <= 1'b0;
                     rr       <= ~gnt1_c;
`ifdef DMA_ARB_BURST_EN
                     burst_cnt <= '0;
`endif
                  end
               end
            end
            default: state <= HALT;
         endcase
      end
   end

   assign bus.ack0     = (state == GRANT0) & bus.dma_ready;
   assign bus.ack1     = (state == GRANT1) & bus.dma_ready;
   assign bus.dout     = bus.dma_dout;
   assign bus.dma_en   = dma_en_q;
   assign bus.dma_addr = dma_addr_q;
   assign bus.dma_we   = dma_we_q;
   assign bus.dma_din  = dma_din_q;

endmodule

// File: tb/tb_dma_arbiter.sv
// Directed bench for dma_arbiter: transaction-level reference model checked every cycle plus literal expectations.
module tb_dma_arbiter;

`ifdef DMA_ARB_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif
   localparam int MAXB = 8;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [15:0] pc = 16'h1234;
   logic        key_violation;

   int checks = 0;
   int errors = 0;

   dma_arbiter_if bus ();

   dma_arbiter dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .pc            (pc),
      .bus           (bus),
      .key_violation (key_violation)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: who owns the bus, how many beats done, whether halted
   bit          m_halt  = 1'b1;
   int          m_owner = -1;
   int          m_pref  = 0;
   int          m_beats = 0;
   bit          m_en    = 1'b0;
   logic [15:0] m_addr  = 16'h0000;
   logic [15:0] m_din   = 16'h0000;
   bit          m_we    = 1'b0;

   function automatic bit kreg(input logic [15:0] a);
      int v;
      v = a;
      return (v >= 'hFEFE) && (v < 'hFEFE + 'h1F);
   endfunction

   function automatic logic [15:0] addr_of(input int m);
      return (m == 1) ? bus.addr1 : bus.addr0;
   endfunction
   function automatic logic [15:0] din_of(input int m);
      return (m == 1) ? bus.din1 : bus.din0;
   endfunction
   function automatic bit we_of(input int m);
      return (m == 1) ? bus.we1 : bus.we0;
   endfunction
   function automatic bit req_of(input int m);
      return (m == 1) ? bus.req1 : bus.req0;
   endfunction
   function automatic bit lock_of(input int m);
      return (m == 1) ? bus.lock1 : bus.lock0;
   endfunction
   function automatic int pick();
      if (bus.req0 && bus.req1) return m_pref;
      if (bus.req0) return 0;
      if (bus.req1) return 1;
      return -1;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_halt <= 1'b1; m_owner <= -1; m_pref <= 0; m_beats <= 0;
         m_en <= 1'b0; m_addr <= 16'h0000; m_din <= 16'h0000; m_we <= 1'b0;
      end else if (m_halt) begin
         if (pc == 16'h0000) m_halt <= 1'b0;
      end else if (m_owner < 0) begin
         if (pick() >= 0) begin
            if (kreg(addr_of(pick()))) m_halt <= 1'b1;
            else begin
               m_en <= 1'b1; m_addr <= addr_of(pick()); m_din <= din_of(pick());
               m_we <= we_of(pick()); m_owner <= pick(); m_beats <= 0;
            end
         end
      end else if (bus.dma_ready) begin
         if (BURST && lock_of(m_owner) && req_of(m_owner) && (m_beats + 1 < MAXB)) begin
            if (kreg(addr_of(m_owner))) begin
               m_halt <= 1'b1; m_en <= 1'b0; m_owner <= -1;
            end else begin
               m_addr <= addr_of(m_owner); m_din <= din_of(m_owner);
               m_we <= we_of(m_owner); m_beats <= m_beats + 1;
            end
         end else begin
            m_en <= 1'b0; m_pref <= 1 - m_owner; m_owner <= -1;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      chk("key_violation", key_violation, m_halt);
      chk("dma_en", bus.dma_en, m_en);
      chk("dma_addr", bus.dma_addr, m_addr);
      chk("dma_we", bus.dma_we, m_we);
      chk("dma_din", bus.dma_din, m_din);
      chk("ack0", bus.ack0, !m_halt && m_owner == 0 && bus.dma_ready);
      chk("ack1", bus.ack1, !m_halt && m_owner == 1 && bus.dma_ready);
      chk("dout", bus.dout, bus.dma_dout);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int ack_code();
      return bus.ack0 ? 1 : (bus.ack1 ? 2 : 0);
   endfunction

   int fexp [8];
   int bexp [12];
   int codes[12];
   logic [15:0] addrs[12];
   int en_cnt;
   int run;

   initial begin
      bus.req0 = 0; bus.req1 = 0; bus.addr0 = 0; bus.addr1 = 0;
      bus.we0 = 0; bus.we1 = 0; bus.din0 = 0; bus.din1 = 0;
      bus.lock0 = 0; bus.lock1 = 0; bus.dma_ready = 0; bus.dma_dout = 0;

      // Reset and release through the reset-handler fetch
      #1 reset_n = 1'b0;
      #2;
      chk("rst_kv", key_violation, 1);
      chk("rst_en", bus.dma_en, 0);
      @(posedge clk); #1 reset_n = 1'b1;
      repeat (5) step();
      chk("halt_hold_kv", key_violation, 1);
      chk("halt_hold_en", bus.dma_en, 0);
      pc = 16'h0000;
      step();
      chk("halt_exit_kv", key_violation, 0);
      pc = 16'h1234;

      // Fairness with both masters requesting
      bus.addr0 = 16'h0100; bus.addr1 = 16'h0300;
      bus.we1 = 1'b1; bus.din1 = 16'hA5A5;
      bus.dma_dout = 16'h1111; bus.dma_ready = 1'b1;
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      fexp = '{0, 1, 0, 2, 0, 1, 0, 2};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         codes[i] = ack_code();
         addrs[i] = bus.dma_addr;
      end
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("fair_ack%0d", i), codes[i], fexp[i]);
         if (fexp[i] == 1) chk($sformatf("fair_addr%0d", i), addrs[i], 16'h0100);
         if (fexp[i] == 2) chk($sformatf("fair_addr%0d", i), addrs[i], 16'h0300);
      end
      step();
      bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we1 = 1'b0;

      // Read with three-cycle bus latency
      bus.addr0 = 16'h0200; bus.dma_ready = 1'b0; bus.dma_dout = 16'hBEEF;
      bus.req0 = 1'b1;
      step();
      en_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) bus.dma_ready = 1'b1;
         @(negedge clk);
         en_cnt += int'(bus.dma_en);
         chk($sformatf("rd_ack%0d", i), bus.ack0, (i == 2) ? 1 : 0);
         if (i < 2) step();
      end
      chk("rd_dout", bus.dout, 16'hBEEF);
      chk("rd_en_cycles", en_cnt, 3);
      step();
      bus.req0 = 1'b0; bus.dma_ready = 1'b1;

      // Key-region screening and its boundaries
      bus.addr1 = 16'hFF00; bus.req1 = 1'b1;
      step();
      @(negedge clk);
      chk("key_kv", key_violation, 1);
      chk("key_en", bus.dma_en, 0);
      chk("key_ack1", bus.ack1, 0);
      step(); step();
      chk("key_hold_kv", key_violation, 1);
      bus.addr1 = 16'hFF1D; pc = 16'h0000;
      step();
      chk("key_exit_kv", key_violation, 0);
      pc = 16'h1234;
      step();
      @(negedge clk);
      chk("end_edge_ack1", bus.ack1, 1);
      chk("end_edge_addr", bus.dma_addr, 16'hFF1D);
      step();
      bus.addr1 = 16'hFEFD;
      step();
      @(negedge clk);
      chk("low_edge_ack1", bus.ack1, 1);
      chk("low_edge_addr", bus.dma_addr, 16'hFEFD);
      step();
      bus.req1 = 1'b0;

      // Burst lock on master 0 while master 1 waits
      bus.addr0 = 16'h0400; bus.addr1 = 16'h0500;
      bus.lock0 = 1'b1; bus.req0 = 1'b1; bus.req1 = 1'b1;
      if (BURST) bexp = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 2, 0};
      else       bexp = '{0, 1, 0, 2, 0, 1, 0, 2, 0, 1, 0, 2};
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         codes[i] = ack_code();
      end
      run = 0;
      for (int i = 1; i < 12; i++) begin
         if (codes[i] != 1) break;
         run++;
      end
      chk("burst_len", run, BURST ? MAXB : 1);
      for (int i = 0; i < 12; i++) chk($sformatf("burst_ack%0d", i), codes[i], bexp[i]);
      step();
      reset_n = 1'b0;
      bus.req0 = 1'b0; bus.req1 = 1'b0; bus.lock0 = 1'b0;
      step();
      reset_n = 1'b1; pc = 16'h0000;
      step();
      pc = 16'h1234;

      // Reset during the third transfer of a burst
      bus.addr0 = 16'h0600; bus.lock0 = 1'b1; bus.req0 = 1'b1; bus.req1 = 1'b1;
      step(); step(); step();
      chk("mid_en_before", bus.dma_en, 1);
      reset_n = 1'b0;
      #1;
      chk("mid_en_after", bus.dma_en, 0);
      chk("mid_ack0", bus.ack0, 0);
      chk("mid_ack1", bus.ack1, 0);
      chk("mid_kv", key_violation, 1);
      bus.req0 = 1'b0; bus.req1 = 1'b0; bus.lock0 = 1'b0;
      step();
      reset_n = 1'b1;
      step(); step();
      chk("mid_hold_kv", key_violation, 1);
      pc = 16'h0000;
      step();
      chk("mid_exit_kv", key_violation, 0);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired got running want finished");
      $fatal(1, "watchdog");
   end

endmodule
